scan_multi_chain: RTL and testbench

//   Parametrised multi-chain scan register for the BIST-per-scan datapath.
//   NUM_CHAINS parallel chains of CHAIN_LEN flops each, with manual shift/capture

---
 rtl/scan_multi_chain_if.sv | 32 +++
 rtl/scan_multi_chain.sv | 126 ++++++++++++
 tb/tb_scan_multi_chain.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/scan_multi_chain_if.sv
// Bundle of control, data and status signals for scan_multi_chain.
//   master: driver side (test pattern generator / sequencer owner)
//     test_control, mode, start, scan_in, capture_data   -> driven
//     scan_out, chain_q, busy, done, shift_count          <- observed
//   slave: the scan register itself (directions reversed)
interface scan_multi_chain_if #(
    parameter int NUM_CHAINS = 4,
    parameter int CHAIN_LEN  = 7
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    logic                             test_control;
    logic [1:0]                       mode;
    logic                             start;
    logic [NUM_CHAINS-1:0]            scan_in;
    logic [NUM_CHAINS*CHAIN_LEN-1:0]  capture_data;
    logic [NUM_CHAINS-1:0]            scan_out;
    logic [NUM_CHAINS*CHAIN_LEN-1:0]  chain_q;
    logic                             busy;
    logic                             done;
    logic [CNT_W-1:0]                 shift_count;

    modport master (
        output test_control, mode, start, scan_in, capture_data,
        input  scan_out, chain_q, busy, done, shift_count
    );

    modport slave (
        input  test_control, mode, start, scan_in, capture_data,
        output scan_out, chain_q, busy, done, shift_count
    );
endinterface

// File: rtl/scan_multi_chain.sv
// Multi-chain scan register with manual shift/capture control and an
// automatic load/unload sequencer (CHAIN_LEN shifts, one capture, done pulse).
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high; overrides everything
//   bus    - scan_multi_chain_if.slave: test_control, mode, start, scan_in,
//            capture_data in; scan_out, chain_q, busy, done, shift_count out
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | not busy; start launches a sequence, else manual mode applies
// SHIFT   | shifting all chains once per cycle, counting shifts
// CAPTURE | loading capture_data into every chain
// DONE    | one-cycle done pulse, chains held
module scan_multi_chain #(
    parameter int NUM_CHAINS = 4,
    parameter int CHAIN_LEN  = 7
) (
    input logic             clock,
    input logic             reset,
    scan_multi_chain_if.slave bus
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int W     = NUM_CHAINS * CHAIN_LEN;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [W-1:0]          chain;
    logic [NUM_CHAINS-1:0] so;
    logic [CNT_W-1:0]      cnt;
    logic                  do_shift, do_capture, clr_cnt, inc_cnt;
    logic                  busy_c, done_c;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_shift   = 1'b0;
        do_capture = 1'b0;
        clr_cnt    = 1'b0;
        inc_cnt    = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.test_control && bus.start) begin
                    state_next = ST_SHIFT;
                    clr_cnt    = 1'b1;
                end else if (bus.test_control) begin
                    do_shift   = (bus.mode == 2'b01);
                    do_capture = (bus.mode == 2'b10);
                end
            end
            ST_SHIFT: begin
                busy_c = 1'b1;
                // Dropping test_control aborts without touching chains or count.
                if (!bus.test_control) begin
                    state_next = ST_IDLE;
                end else begin
                    do_shift = 1'b1;
                    inc_cnt  = 1'b1;
                    if (cnt == CNT_W'(CHAIN_LEN - 1)) begin
                        state_next = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                busy_c = 1'b1;
                if (!bus.test_control) begin
                    state_next = ST_IDLE;
                end else begin
                    do_capture = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_c     = 1'b1;
                done_c     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            chain <= '0;
            so    <= '0;
            cnt   <= '0;
        end else begin
            if (clr_cnt) begin
                cnt <= '0;
            end else if (inc_cnt) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (do_capture) begin
                chain <= bus.capture_data;
            end else if (do_shift) begin
                // Each chain shifts toward bit 0; scan_in enters at the top.
                for (int c = 0; c < NUM_CHAINS; c++) begin
                    chain[c*CHAIN_LEN +: CHAIN_LEN] <=
                        {bus.scan_in[c], chain[c*CHAIN_LEN+1 +: CHAIN_LEN-1]};
                    so[c] <= chain[c*CHAIN_LEN];
                end
            end
        end
    end

    assign bus.chain_q     = chain;
    assign bus.scan_out    = so;
    assign bus.shift_count = cnt;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
endmodule

// File: tb/tb_scan_multi_chain.sv
module tb_scan_multi_chain;
    localparam int NC = 4;
    localparam int L  = 7;
    localparam int W  = NC * L;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    scan_multi_chain_if #(.NUM_CHAINS(NC), .CHAIN_LEN(L)) bus ();

    scan_multi_chain #(.NUM_CHAINS(NC), .CHAIN_LEN(L)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic         tc;
        logic [1:0]   mode;
        logic [NC-1:0] si;
        logic [W-1:0] cap;
        logic [W-1:0] exp_q;
        logic [NC-1:0] exp_so;
    } vec_t;
    vec_t vecs[6];

    // reference model: each chain as a plain number, sequence as an edge count
    logic [L-1:0]  m[NC];
    logic [NC-1:0] mso;
    int            steps;
    int            mcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic tc, input logic [1:0] md, input logic st,
                         input logic [NC-1:0] si, input logic [W-1:0] cap);
        bus.test_control = tc;
        bus.mode         = md;
        bus.start        = st;
        bus.scan_in      = si;
        bus.capture_data = cap;
    endtask

    task automatic m_shift();
        for (int c = 0; c < NC; c++) begin
            mso[c] = m[c][0];
            m[c]   = (m[c] >> 1) | (L'(bus.scan_in[c]) << (L - 1));
        end
    endtask

    task automatic m_capture();
        for (int c = 0; c < NC; c++) m[c] = bus.capture_data[c*L +: L];
    endtask

    task automatic model_edge();
        if (reset) begin
            for (int c = 0; c < NC; c++) m[c] = '0;
            mso = '0; steps = 0; mcnt = 0;
        end else if (steps == 0) begin
            if (bus.test_control && bus.start) begin
                steps = 1; mcnt = 0;
            end else if (bus.test_control && bus.mode == 2'b01) m_shift();
            else if (bus.test_control && bus.mode == 2'b10) m_capture();
        end else if (!bus.test_control) begin
            steps = 0;
        end else if (steps <= L) begin
            m_shift(); mcnt++; steps++;
        end else if (steps == L + 1) begin
            m_capture(); steps++;
        end else begin
            steps = 0;
        end
    endtask

    function automatic logic [W-1:0] m_flat();
        logic [W-1:0] r;
        for (int c = 0; c < NC; c++) r[c*L +: L] = m[c];
        return r;
    endfunction

    task automatic run_seq(input bit noisy);
        int busy_n = 0;
        int done_n = 0;
        drive(1'b1, 2'b00, 1'b1, 4'hF, 28'h1234567);
        step();
        for (int j = 0; j <= 10; j++) begin
            chk("seq_count", 64'(bus.shift_count), 64'(j <= 7 ? j : 7));
            chk("seq_busy", 64'(bus.busy), 64'(j <= 8));
            chk("seq_done", 64'(bus.done), 64'(j == 8));
            if (j == 7) chk("seq_shifted", 64'(bus.chain_q), 64'(28'hFFFFFFF));
            if (j == 8) chk("seq_capture", 64'(bus.chain_q), 64'(28'h1234567));
            busy_n += int'(bus.busy);
            done_n += int'(bus.done);
            bus.start = (noisy && j < 8) ? j[0] : 1'b0;
            bus.mode  = (noisy && j < 7 && j % 2 == 0) ? 2'b01 : 2'b00;
            step();
        end
        chk("seq_busy_cycles", 64'(busy_n), 64'd9);
        chk("seq_done_pulses", 64'(done_n), 64'd1);
    endtask

    initial begin
        drive(1'b0, 2'b00, 1'b0, '0, '0);
        step();
        reset = 1'b0;

        // load all ones, then reset must clear everything
        drive(1'b1, 2'b10, 1'b0, 4'hF, 28'hFFFFFFF);
        step();
        bus.mode = 2'b01;
        step();
        chk("preload_q", 64'(bus.chain_q), 64'(28'hFFFFFFF));
        chk("preload_so", 64'(bus.scan_out), 64'(4'hF));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_q", 64'(bus.chain_q), 64'd0);
        chk("rst_so", 64'(bus.scan_out), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_count", 64'(bus.shift_count), 64'd0);

        // manual op table, applied in order from the cleared state
        vecs[0] = '{1'b1, 2'b10, 4'h0, 28'hA5A5A5A, 28'hA5A5A5A, 4'h0};
        vecs[1] = '{1'b1, 2'b00, 4'hF, 28'hFFFFFFF, 28'hA5A5A5A, 4'h0};
        vecs[2] = '{1'b0, 2'b10, 4'hF, 28'h0123456, 28'hA5A5A5A, 4'h0};
        vecs[3] = '{1'b1, 2'b11, 4'hF, 28'h0123456, 28'hA5A5A5A, 4'h0};
        vecs[4] = '{1'b1, 2'b01, 4'b1010, 28'h0, {7'h69, 7'h34, 7'h5A, 7'h2D}, 4'b0100};
        vecs[5] = '{1'b0, 2'b01, 4'hF, 28'h0, {7'h69, 7'h34, 7'h5A, 7'h2D}, 4'b0100};
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].tc, vecs[i].mode, 1'b0, vecs[i].si, vecs[i].cap);
            step();
            chk($sformatf("vec%0d_q", i), 64'(bus.chain_q), 64'(vecs[i].exp_q));
            chk($sformatf("vec%0d_so", i), 64'(bus.scan_out), 64'(vecs[i].exp_so));
        end

        // shift latency: one bit travels scan_in -> scan_out in L+1 clocks
        reset = 1'b1; step(); reset = 1'b0;
        drive(1'b1, 2'b01, 1'b0, 4'b0001, '0);
        step();
        chk("lat_top_bit", 64'(bus.chain_q[L-1]), 64'd1);
        bus.scan_in = '0;
        for (int k = 2; k <= L + 1; k++) begin
            step();
            chk($sformatf("lat_so_edge%0d", k), 64'(bus.scan_out), 64'(k == L + 1 ? 1 : 0));
        end

        // manual capture leaves scan_out alone
        drive(1'b1, 2'b10, 1'b0, 4'hF, 28'hA5A5A5A);
        step();
        chk("cap_q", 64'(bus.chain_q), 64'(28'hA5A5A5A));
        chk("cap_so", 64'(bus.scan_out), 64'(4'b0001));

        // automatic sequence, quiet and with start/mode noise while busy
        run_seq(1'b0);
        run_seq(1'b1);

        // abort by dropping test_control after 3 shifts
        reset = 1'b1; step(); reset = 1'b0;
        drive(1'b1, 2'b00, 1'b1, 4'hF, 28'hFFFFFFF);
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("abort_pre_count", 64'(bus.shift_count), 64'd3);
        chk("abort_pre_q", 64'(bus.chain_q), 64'({4{7'h70}}));
        bus.test_control = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("abort_busy", 64'(bus.busy), 64'd0);
            chk("abort_done", 64'(bus.done), 64'd0);
            chk("abort_count", 64'(bus.shift_count), 64'd3);
            chk("abort_q", 64'(bus.chain_q), 64'({4{7'h70}}));
            bus.mode  = 2'b01;
            bus.start = 1'b1;
        end

        // reset in the middle of a sequence
        drive(1'b1, 2'b00, 1'b1, 4'hF, 28'hFFFFFFF);
        step();
        bus.start = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_q", 64'(bus.chain_q), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_count", 64'(bus.shift_count), 64'd0);
        step();
        chk("midrst_nodone", 64'(bus.done), 64'd0);
        chk("midrst_idle", 64'(bus.busy), 64'd0);

        // randomized run against the reference model
        reset = 1'b1;
        model_edge();
        step();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(63) == 0);
            drive($urandom_range(7) != 0, 2'($urandom_range(3)), $urandom_range(5) == 0,
                  NC'($urandom), W'($urandom));
            model_edge();
            step();
            chk("rnd_q", 64'(bus.chain_q), 64'(m_flat()));
            chk("rnd_so", 64'(bus.scan_out), 64'(mso));
            chk("rnd_busy", 64'(bus.busy), 64'(steps != 0));
            chk("rnd_done", 64'(bus.done), 64'(steps == L + 2));
            chk("rnd_count", 64'(bus.shift_count), 64'(mcnt));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
